// File: rtl/lsu_sq_retire_arb_if.sv
// Bundle for the LSU D$ port arbiter: RS op request, SQ retiring store,
// D$ stage handshake, and the SQ update/retry result. Widths stand in for
// the procyon addr/data/tag/lsu_func types.
interface lsu_sq_retire_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int FUNC_W = 3
);
  logic              i_flush;
  logic              i_rs_en;
  logic [ADDR_W-1:0] i_rs_addr;
  logic [DATA_W-1:0] i_rs_data;
  logic [TAG_W-1:0]  i_rs_tag;
  logic [FUNC_W-1:0] i_rs_lsu_func;
  logic              o_rs_stall;
  logic              i_sq_retire_en;
  logic [ADDR_W-1:0] i_sq_retire_addr;
  logic [DATA_W-1:0] i_sq_retire_data;
  logic [TAG_W-1:0]  i_sq_retire_tag;
  logic [FUNC_W-1:0] i_sq_retire_lsu_func;
  logic              o_sq_retire_stall;
  logic              o_update_sq_en;
  logic              o_update_sq_retry;
  logic              i_dc_stall;
  logic              i_dc_accept;
  logic              o_dc_en;
  logic [ADDR_W-1:0] o_dc_addr;
  logic [DATA_W-1:0] o_dc_data;
  logic [TAG_W-1:0]  o_dc_tag;
  logic [FUNC_W-1:0] o_dc_lsu_func;
  logic              o_dc_retire;

  // LSU side: drives requests and D$ status, observes grants and results
  modport master (
    output i_flush, i_rs_en, i_rs_addr, i_rs_data, i_rs_tag, i_rs_lsu_func,
    output i_sq_retire_en, i_sq_retire_addr, i_sq_retire_data, i_sq_retire_tag,
    output i_sq_retire_lsu_func, i_dc_stall, i_dc_accept,
    input  o_rs_stall, o_sq_retire_stall, o_update_sq_en, o_update_sq_retry,
    input  o_dc_en, o_dc_addr, o_dc_data, o_dc_tag, o_dc_lsu_func, o_dc_retire
  );

  // Arbiter side
  modport slave (
    input  i_flush, i_rs_en, i_rs_addr, i_rs_data, i_rs_tag, i_rs_lsu_func,
    input  i_sq_retire_en, i_sq_retire_addr, i_sq_retire_data, i_sq_retire_tag,
    input  i_sq_retire_lsu_func, i_dc_stall, i_dc_accept,
    output o_rs_stall, o_sq_retire_stall, o_update_sq_en, o_update_sq_retry,
    output o_dc_en, o_dc_addr, o_dc_data, o_dc_tag, o_dc_lsu_func, o_dc_retire
  );
endinterface

// File: rtl/lsu_sq_retire_arb.sv
// lsu_sq_retire_arb: arbitrates the single D$ port between the retiring SQ
// store and the RS-issued op, registers the winner into the D$ stage and
// returns the SQ update/retry result one cycle after a store grant.
// Optional: define LSU_SQ_RETRY_BACKOFF_EN to hold off store retire for
// RETRY_BACKOFF cycles after a retried store.
module lsu_sq_retire_arb #(
  parameter int STARVE_MAX    = 4,
  parameter int RETRY_BACKOFF = 3,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TAG_W         = 6,
  parameter int FUNC_W        = 3
) (
  input logic               clk,
  input logic               n_rst,
  lsu_sq_retire_arb_if.slave bus
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  if ((STARVE_MAX < 1) || (RETRY_BACKOFF < 1)) begin : g_param_check
    $error("lsu_sq_retire_arb: STARVE_MAX and RETRY_BACKOFF must be >= 1");
  end

  logic              sq_grant_s;
  logic              rs_grant_s;
  logic              fsm_idle_s;
  logic              update_retry_s;
  logic [SCW-1:0]    starve_cnt_r;
  logic              dc_en_r;
  logic              dc_retire_r;
  logic              update_en_r;
  logic [ADDR_W-1:0] dc_addr_r;
  logic [DATA_W-1:0] dc_data_r;
  logic [TAG_W-1:0]  dc_tag_r;
  logic [FUNC_W-1:0] dc_func_r;

  // The retry flag qualifies the store currently on the D$ stage
  assign update_retry_s = update_en_r & ~bus.i_dc_accept;

`ifdef LSU_SQ_RETRY_BACKOFF_EN
  localparam int BCW = (RETRY_BACKOFF > 1) ? $clog2(RETRY_BACKOFF) : 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_BACKOFF = 1'b1
  } fsm_e;

  fsm_e           state_r;
  fsm_e           state_s;
  logic [BCW-1:0] backoff_cnt_r;
  logic [BCW-1:0] backoff_cnt_s;

  // Back-off FSM state and window counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      backoff_cnt_r <= {BCW{1'b0}};
    end else begin
      state_r       <= state_s;
      backoff_cnt_r <= backoff_cnt_s;
    end
  end

  // Enter back-off on a retried store, leave once the window has counted out
  always_comb begin
    state_s       = state_r;
    backoff_cnt_s = backoff_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (update_retry_s) begin
          state_s       = ST_BACKOFF;
          backoff_cnt_s = BCW'(RETRY_BACKOFF - 1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BACKOFF: begin
        if (backoff_cnt_r == {BCW{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          backoff_cnt_s = backoff_cnt_r - BCW'(1);
        end
      end
      default: begin
        state_s       = ST_IDLE;
        backoff_cnt_s = {BCW{1'b0}};
      end
    endcase
  end

  assign fsm_idle_s = (state_r == ST_IDLE);
`else
  assign fsm_idle_s = 1'b1;
`endif

  // Grant: store first unless backing off, starving RS, or its last attempt
  // is being retried right now; RS op otherwise, never during flush
  always_comb begin
    sq_grant_s = 1'b0;
    rs_grant_s = 1'b0;
    if (n_rst && !bus.i_dc_stall) begin
      if (bus.i_sq_retire_en && fsm_idle_s && !update_retry_s &&
          (starve_cnt_r != STARVE_LIM)) begin
        sq_grant_s = 1'b1;
      end else if (bus.i_rs_en && !bus.i_flush) begin
        rs_grant_s = 1'b1;
      end else begin
        sq_grant_s = 1'b0;
        rs_grant_s = 1'b0;
      end
    end else begin
      sq_grant_s = 1'b0;
      rs_grant_s = 1'b0;
    end
  end

  assign bus.o_rs_stall        = bus.i_rs_en & ~rs_grant_s;
  assign bus.o_sq_retire_stall = bus.i_sq_retire_en & ~sq_grant_s;

  // Count consecutive cycles a waiting RS op lost to a store retire
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (bus.i_flush) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (bus.i_dc_stall) begin
      starve_cnt_r <= starve_cnt_r;
    end else if (rs_grant_s || !bus.i_rs_en) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (sq_grant_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + SCW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // D$ stage register: winner's payload; payload holds when nothing wins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dc_en_r     <= 1'b0;
      dc_retire_r <= 1'b0;
      update_en_r <= 1'b0;
      dc_addr_r   <= {ADDR_W{1'b0}};
      dc_data_r   <= {DATA_W{1'b0}};
      dc_tag_r    <= {TAG_W{1'b0}};
      dc_func_r   <= {FUNC_W{1'b0}};
    end else begin
      dc_en_r     <= sq_grant_s | rs_grant_s;
      dc_retire_r <= sq_grant_s;
      update_en_r <= sq_grant_s;
      if (sq_grant_s) begin
        dc_addr_r <= bus.i_sq_retire_addr;
        dc_data_r <= bus.i_sq_retire_data;
        dc_tag_r  <= bus.i_sq_retire_tag;
        dc_func_r <= bus.i_sq_retire_lsu_func;
      end else if (rs_grant_s) begin
        dc_addr_r <= bus.i_rs_addr;
        dc_data_r <= bus.i_rs_data;
        dc_tag_r  <= bus.i_rs_tag;
        dc_func_r <= bus.i_rs_lsu_func;
      end
    end
  end

  assign bus.o_dc_en           = dc_en_r;
  assign bus.o_dc_retire       = dc_retire_r;
  assign bus.o_dc_addr         = dc_addr_r;
  assign bus.o_dc_data         = dc_data_r;
  assign bus.o_dc_tag          = dc_tag_r;
  assign bus.o_dc_lsu_func     = dc_func_r;
  assign bus.o_update_sq_en    = update_en_r;
  assign bus.o_update_sq_retry = update_retry_s;

endmodule

// File: tb/tb_lsu_sq_retire_arb.sv
// Directed, table-driven bench for lsu_sq_retire_arb (STARVE_MAX=4,
// RETRY_BACKOFF=3). Expectations follow LSU_SQ_RETRY_BACKOFF_EN if defined.
`timescale 1ns/1ps
module tb_lsu_sq_retire_arb;

  logic clk;
  logic n_rst;
  int   n_vec;
  int   n_bad;

  lsu_sq_retire_arb_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(6), .FUNC_W(3)) bus ();

  lsu_sq_retire_arb #(
    .STARVE_MAX(4), .RETRY_BACKOFF(3),
    .ADDR_W(32), .DATA_W(32), .TAG_W(6), .FUNC_W(3)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    bit         rs, sq, fl, st, acc;
    logic [5:0] rt, qt;
    logic [11:0] exp;  // {rs_stall, sq_stall, dc_en, dc_retire, dc_tag, upd_en, upd_retry}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input bit rs, sq, fl, st, acc,
                     input int rt, qt,
                     input bit ers, esq, eden, eret, input int etag,
                     input bit eupd, eretry);
    vec_t v;
    v.name = n; v.rs = rs; v.sq = sq; v.fl = fl; v.st = st; v.acc = acc;
    v.rt = 6'(rt); v.qt = 6'(qt);
    v.exp = {ers, esq, eden, eret, 6'(etag), eupd, eretry};
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // Payload encodings so RS and SQ payloads are distinguishable by tag
  function automatic logic [31:0] rs_addr(input logic [5:0] t); return 32'hA000_0000 | {26'd0, t}; endfunction
  function automatic logic [31:0] rs_data(input logic [5:0] t); return 32'hD500_0000 | {26'd0, t}; endfunction
  function automatic logic [31:0] sq_addr(input logic [5:0] t); return 32'hB000_0000 | {26'd0, t}; endfunction
  function automatic logic [31:0] sq_data(input logic [5:0] t); return 32'hC500_0000 | {26'd0, t}; endfunction

  task automatic set_in(input bit rs, sq, fl, st, acc, input logic [5:0] rt, qt);
    bus.i_rs_en = rs; bus.i_rs_tag = rt; bus.i_rs_addr = rs_addr(rt);
    bus.i_rs_data = rs_data(rt); bus.i_rs_lsu_func = 3'd1;
    bus.i_sq_retire_en = sq; bus.i_sq_retire_tag = qt; bus.i_sq_retire_addr = sq_addr(qt);
    bus.i_sq_retire_data = sq_data(qt); bus.i_sq_retire_lsu_func = 3'd2;
    bus.i_flush = fl; bus.i_dc_stall = st; bus.i_dc_accept = acc;
  endtask

  // Drive at the falling edge, leave the bench 1ns before the rising edge
  task automatic drive(input bit rs, sq, fl, st, acc, input logic [5:0] rt, qt);
    @(negedge clk);
    set_in(rs, sq, fl, st, acc, rt, qt);
    #4;
  endtask

  function automatic logic [11:0] obs();
    return {bus.o_rs_stall, bus.o_sq_retire_stall, bus.o_dc_en, bus.o_dc_retire,
            bus.o_dc_tag, bus.o_update_sq_en, bus.o_update_sq_retry};
  endfunction

  function automatic logic [63:0] obs_all();
    return {bus.o_dc_en, bus.o_dc_retire, bus.o_update_sq_en, bus.o_update_sq_retry,
            bus.o_rs_stall, bus.o_sq_retire_stall, bus.o_dc_tag, bus.o_dc_lsu_func,
            bus.o_dc_addr[23:0], bus.o_dc_data[23:0]};
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    //   name           rs sq fl st ac rt qt | rss sqs den ret tag upd rty
    add("idle",          0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add("sq_grant_t5",   0, 1, 0, 0, 1, 0, 5,  0, 0, 0, 0, 0, 0, 0);
    add("sq_update_ok",  0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 5, 1, 0);
    add("rs_grant_t9",   1, 0, 0, 0, 1, 9, 0,  0, 0, 0, 0, 5, 0, 0);
    add("rs_on_dc",      0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 9, 0, 0);
    add("starve_c0",     1, 1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 9, 0, 0);
    add("starve_c1",     1, 1, 0, 0, 1, 1, 11, 1, 0, 1, 1, 10, 1, 0);
    add("starve_c2",     1, 1, 0, 0, 1, 1, 12, 1, 0, 1, 1, 11, 1, 0);
    add("starve_c3",     1, 1, 0, 0, 1, 1, 13, 1, 0, 1, 1, 12, 1, 0);
    add("starve_rs_win", 1, 1, 0, 0, 1, 1, 14, 0, 1, 1, 1, 13, 1, 0);
    add("starve_back0",  1, 1, 0, 0, 1, 2, 15, 1, 0, 1, 0, 1, 0, 0);
    add("dcstall_1",     1, 1, 0, 1, 1, 3, 16, 1, 1, 1, 1, 15, 1, 0);
    add("dcstall_2",     1, 1, 0, 1, 1, 3, 16, 1, 1, 0, 0, 15, 0, 0);
    add("dcstall_3",     1, 1, 0, 1, 1, 3, 16, 1, 1, 0, 0, 15, 0, 0);
    add("post_stall_c1", 1, 1, 0, 0, 1, 4, 17, 1, 0, 0, 0, 15, 0, 0);
    add("post_stall_c2", 1, 1, 0, 0, 1, 4, 18, 1, 0, 1, 1, 17, 1, 0);
    add("post_stall_c3", 1, 1, 0, 0, 1, 4, 19, 1, 0, 1, 1, 18, 1, 0);
    add("post_stall_rs", 1, 1, 0, 0, 1, 4, 20, 0, 1, 1, 1, 19, 1, 0);
    add("flush_rs",      1, 0, 1, 0, 1, 7, 0,  1, 0, 1, 0, 4, 0, 0);
    add("flush_no_dc",   0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 4, 0, 0);
    add("flush_sq_wins", 1, 1, 1, 0, 1, 8, 21, 1, 0, 0, 0, 4, 0, 0);
    add("flush_sq_upd",  0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 21, 1, 0);
    add("fclr_c0",       1, 1, 0, 0, 1, 9, 22, 1, 0, 0, 0, 21, 0, 0);
    add("fclr_c1",       1, 1, 0, 0, 1, 9, 23, 1, 0, 1, 1, 22, 1, 0);
    add("fclr_c2",       1, 1, 0, 0, 1, 9, 24, 1, 0, 1, 1, 23, 1, 0);
    add("fclr_flush",    1, 1, 1, 0, 1, 9, 25, 1, 0, 1, 1, 24, 1, 0);
    add("fclr_sq_again", 1, 1, 0, 0, 1, 9, 26, 1, 0, 1, 1, 25, 1, 0);
    add("fclr_idle",     0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 1, 26, 1, 0);

    // Reset state with both requesters asserting
    n_rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3, 6'd4);
    #2;
    chk("reset_state", obs_all(), {4'b0000, 2'b11, 6'd0, 3'd0, 24'd0, 24'd0});
    @(negedge clk);
    n_rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].sq, vecs[i].fl, vecs[i].st, vecs[i].acc, vecs[i].rt, vecs[i].qt);
      chk(vecs[i].name, {52'd0, obs()}, {52'd0, vecs[i].exp});
    end

    // Full payload of an RS op and of a store
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk("payload_rs", {bus.o_dc_retire, bus.o_dc_lsu_func, bus.o_dc_addr, bus.o_dc_data},
        {1'b0, 3'd1, rs_addr(6'd12), rs_data(6'd12)});
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd13);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk("payload_sq", {bus.o_dc_retire, bus.o_dc_lsu_func, bus.o_dc_addr, bus.o_dc_data},
        {1'b1, 3'd2, sq_addr(6'd13), sq_data(6'd13)});

    // Retried store: blocked in the update cycle, then back-off or immediate
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd30);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd31);
    chk("retry_n1", {52'd0, obs()}, {52'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd30, 1'b1, 1'b1});
`ifdef LSU_SQ_RETRY_BACKOFF_EN
    for (int k = 2; k <= 5; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd31);
      chk($sformatf("retry_n%0d", k), {62'd0, bus.o_update_sq_en, bus.o_sq_retire_stall},
          {62'd0, 1'b0, (k < 5) ? 1'b1 : 1'b0});
    end
`else
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd31);
    chk("retry_n2", {62'd0, bus.o_update_sq_en, bus.o_sq_retire_stall}, {62'd0, 1'b0, 1'b0});
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0);

    // Reset while a retried store puts the arbiter into back-off
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd40);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd40);
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 6'd40);
    n_rst = 1'b0;
    #2;
    chk("reset_midflight", obs_all(), {4'b0000, 2'b11, 6'd0, 3'd0, 24'd0, 24'd0});
    @(negedge clk);
    n_rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd41);
    #4;
    chk("post_reset_grant", {63'd0, bus.o_sq_retire_stall}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk("post_reset_dc", {52'd0, obs()}, {52'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd41, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
